// File: rtl/agc_pkg.sv
`default_nettype none
//============================================================================
// Module : agc_pkg
// Brief  : Shared widths, loop constants, sample/gain types and amplitude table
// Rev    : 1.0 - initial release
//============================================================================
package agc_pkg;

    localparam int DATA_W     = 16;
    localparam int GAIN_W     = 16;
    localparam int TARGET     = 8192;
    localparam int HYST       = 1024;
    localparam int SEG_BLOCKS = 16;

    localparam int PHASE_W    = 8;
    localparam int AMP_W      = 8;
    localparam int IDX_W      = 2;
    localparam int BLK_W      = (SEG_BLOCKS > 1) ? $clog2(SEG_BLOCKS) : 1;
    localparam int GAIN_FRAC  = 8;
    localparam int GAIN_STEP  = 4;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic        [GAIN_W-1:0] gain_t;
    typedef logic        [AMP_W-1:0]  amp_t;

    localparam gain_t             GAIN_UNITY = gain_t'(1 << GAIN_FRAC);
    localparam gain_t             GAIN_MAX   = '1;
    localparam logic [DATA_W-1:0] PEAK_HI    = DATA_W'(TARGET + HYST);
    localparam logic [DATA_W-1:0] PEAK_LO    = DATA_W'(TARGET - HYST);
    localparam logic [BLK_W-1:0]  SEG_LAST   = BLK_W'(SEG_BLOCKS - 1);

    // Amplitude table: {16, 64, 255, 32}
    function automatic amp_t amp_lookup(input logic [IDX_W-1:0] idx);
        amp_t amp;
        case (idx)
            2'd0:    amp = 8'd16;
            2'd1:    amp = 8'd64;
            2'd2:    amp = 8'd255;
            default: amp = 8'd32;
        endcase
        return amp;
    endfunction

endpackage : agc_pkg
`default_nettype wire

// File: rtl/agc_core.sv
`default_nettype none
//============================================================================
// Module : agc_core
// Brief  : Q8.8 gain stage with saturation, block peak detector, gain update
// Rev    : 1.0 - initial release
//============================================================================
module agc_core
    import agc_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  sample_t x,
    input  logic    block_end,
    output sample_t y,
    output gain_t   gain,
    output logic    locked
);

    localparam int PROD_W = DATA_W + GAIN_W + 1;

    localparam logic signed [PROD_W-1:0] SAT_HI  = PROD_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_LO  = ~SAT_HI;
    localparam logic        [DATA_W-1:0] MAG_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam sample_t                  NEG_MAX = {1'b1, {(DATA_W-1){1'b0}}};

    sample_t                  r_y;
    gain_t                    r_gain;
    logic                     r_locked;
    logic        [DATA_W-1:0] r_peak;

    logic signed [PROD_W-1:0] w_x_ext;
    logic signed [PROD_W-1:0] w_g_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_shift;
    sample_t                  w_y_next;
    logic        [DATA_W-1:0] w_mag;
    logic        [DATA_W-1:0] w_blk_peak;
    gain_t                    w_gain_dn;
    logic        [GAIN_W:0]   w_up_wide;
    gain_t                    w_gain_up;
    gain_t                    w_gain_nxt;
    logic                     w_locked_nxt;

    // Gain is unsigned, so it enters the signed product with a zero MSB.
    always_comb begin
        w_x_ext = PROD_W'(x);
        w_g_ext = $signed(PROD_W'({1'b0, r_gain}));
        w_prod  = w_x_ext * w_g_ext;
        w_shift = w_prod >>> GAIN_FRAC;
        if (w_shift > SAT_HI) begin
            w_y_next = SAT_HI[DATA_W-1:0];
        end else if (w_shift < SAT_LO) begin
            w_y_next = SAT_LO[DATA_W-1:0];
        end else begin
            w_y_next = w_shift[DATA_W-1:0];
        end
    end

    // Magnitude folds the most negative code onto the largest positive one.
    always_comb begin
        if (w_y_next == NEG_MAX) begin
            w_mag = MAG_MAX;
        end else if (w_y_next[DATA_W-1]) begin
            w_mag = -w_y_next;
        end else begin
            w_mag = w_y_next;
        end
        w_blk_peak = (w_mag > r_peak) ? w_mag : r_peak;
    end

    always_comb begin
        w_gain_dn = r_gain - (r_gain >> GAIN_STEP);
        if (w_gain_dn == '0) begin
            w_gain_dn = gain_t'(1);
        end
        w_up_wide = {1'b0, r_gain} + (GAIN_W+1)'(r_gain >> GAIN_STEP) + (GAIN_W+1)'(1);
        w_gain_up = w_up_wide[GAIN_W] ? GAIN_MAX : w_up_wide[GAIN_W-1:0];
    end

    always_comb begin
        w_gain_nxt   = r_gain;
        w_locked_nxt = 1'b0;
        if (w_blk_peak > PEAK_HI) begin
            w_gain_nxt = w_gain_dn;
        end else if (w_blk_peak < PEAK_LO) begin
            w_gain_nxt = w_gain_up;
        end else begin
            w_locked_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y      <= '0;
            r_gain   <= GAIN_UNITY;
            r_locked <= 1'b0;
            r_peak   <= '0;
        end else begin
            r_y <= w_y_next;
            if (block_end) begin
                r_peak   <= '0;
                r_gain   <= w_gain_nxt;
                r_locked <= w_locked_nxt;
            end else begin
                r_peak <= w_blk_peak;
            end
        end
    end

    assign y      = r_y;
    assign gain   = r_gain;
    assign locked = r_locked;

endmodule : agc_core
`default_nettype wire

// File: rtl/agc_top.sv
`default_nettype none
//============================================================================
// Module : agc_top
// Brief  : Triangle source stepped through an amplitude table, fed to the AGC
// Rev    : 1.0 - initial release
//============================================================================
module agc_top
    import agc_pkg::*;
(
    input  logic                     i_clock,
    input  logic                     i_reset,
    output logic signed [DATA_W-1:0] o_sample,
    output logic        [GAIN_W-1:0] o_gain,
    output logic                     o_locked,
    output logic        [IDX_W-1:0]  o_amp_idx
);

    localparam sample_t TRI_OFFSET = sample_t'(128);

    logic [PHASE_W-1:0] r_phase;
    logic [BLK_W-1:0]   r_blk_cnt;
    logic [IDX_W-1:0]   r_amp_idx;

    logic [PHASE_W-2:0] w_tri;
    sample_t            w_s;
    sample_t            w_amp;
    sample_t            w_x;
    logic               w_block_end;
    sample_t            w_y;
    gain_t              w_gain;
    logic               w_locked;

    // Both factors are small enough that the 16-bit product is exact.
    always_comb begin
        w_tri       = r_phase[PHASE_W-1] ? ~r_phase[PHASE_W-2:0] : r_phase[PHASE_W-2:0];
        w_s         = $signed(DATA_W'({1'b0, w_tri, 1'b0})) - TRI_OFFSET;
        w_amp       = $signed(DATA_W'(amp_lookup(r_amp_idx)));
        w_x         = w_s * w_amp;
        w_block_end = (r_phase == '1);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + PHASE_W'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_blk_cnt <= '0;
            r_amp_idx <= '0;
        end else if (w_block_end) begin
            if (r_blk_cnt == SEG_LAST) begin
                r_blk_cnt <= '0;
                r_amp_idx <= r_amp_idx + IDX_W'(1);
            end else begin
                r_blk_cnt <= r_blk_cnt + BLK_W'(1);
            end
        end
    end

    agc_core u_core (
        .clk       (i_clock),
        .rst       (i_reset),
        .x         (w_x),
        .block_end (w_block_end),
        .y         (w_y),
        .gain      (w_gain),
        .locked    (w_locked)
    );

    assign o_sample  = w_y;
    assign o_gain    = w_gain;
    assign o_locked  = w_locked;
    assign o_amp_idx = r_amp_idx;

endmodule : agc_top
`default_nettype wire

// File: tb/tb_agc_top.sv
`default_nettype none
//============================================================================
// Module : tb_agc_top
// Brief  : Scoreboard bench for agc_top against a cycle-level reference model
// Rev    : 1.0 - initial release
//============================================================================
module tb_agc_top;

    localparam int BLK = 256;
    localparam int HI  = 8192 + 1024;
    localparam int LO  = 8192 - 1024;

    logic               i_clock = 1'b0;
    logic               i_reset = 1'b1;
    logic signed [15:0] o_sample;
    logic        [15:0] o_gain;
    logic               o_locked;
    logic        [1:0]  o_amp_idx;

    typedef struct {
        int sample;
        int gain;
        int locked;
        int amp;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    int amp_tab[4] = '{16, 64, 255, 32};
    int m_phase, m_gain, m_peak, m_blk, m_amp, m_locked, m_sample;
    int n_samp;

    always #5 i_clock = ~i_clock;

    agc_top dut (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .o_sample  (o_sample),
        .o_gain    (o_gain),
        .o_locked  (o_locked),
        .o_amp_idx (o_amp_idx)
    );

    // Scoreboard: one expected entry per clock, checked just after the edge.
    always @(posedge i_clock) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            total++;
            if (o_sample !== 16'(mon_e.sample) || o_gain !== 16'(mon_e.gain) ||
                o_locked !== 1'(mon_e.locked) || o_amp_idx !== 2'(mon_e.amp)) begin
                bad++;
                $display("FAIL sb n=%0d got sample=%0d gain=%0d locked=%0b amp=%0d want sample=%0d gain=%0d locked=%0d amp=%0d",
                         n_samp, o_sample, o_gain, o_locked, o_amp_idx,
                         mon_e.sample, mon_e.gain, mon_e.locked, mon_e.amp);
            end
        end
    end

    // Drives one clock of stimulus, advancing the model and queueing its outputs.
    task automatic drive_cycle(input logic rst);
        exp_t   e;
        int     tri_v, s, x, y, mag, p;
        longint prod;
        i_reset = rst;
        if (rst) begin
            m_phase = 0; m_gain = 256; m_peak = 0; m_blk = 0;
            m_amp = 0; m_locked = 0; m_sample = 0; n_samp = 0;
        end else begin
            tri_v = (m_phase >= 128) ? 255 - m_phase : m_phase;
            s     = 2 * tri_v - 128;
            x     = s * amp_tab[m_amp];
            prod  = longint'(x) * longint'(m_gain);
            y     = (prod >= 0) ? int'(prod / 256) : int'((prod - 255) / 256);
            if (y > 32767)  y = 32767;
            if (y < -32768) y = -32768;
            mag = (y < 0) ? -y : y;
            if (mag > 32767) mag = 32767;
            p = (mag > m_peak) ? mag : m_peak;
            if (m_phase == 255) begin
                if (p > HI) begin
                    m_gain   = m_gain - m_gain / 16;
                    if (m_gain < 1) m_gain = 1;
                    m_locked = 0;
                end else if (p < LO) begin
                    m_gain   = m_gain + m_gain / 16 + 1;
                    if (m_gain > 65535) m_gain = 65535;
                    m_locked = 0;
                end else begin
                    m_locked = 1;
                end
                m_peak = 0;
                if (m_blk == 15) begin
                    m_blk = 0;
                    m_amp = (m_amp + 1) % 4;
                end else begin
                    m_blk++;
                end
            end else begin
                m_peak = p;
            end
            m_sample = y;
            m_phase  = (m_phase + 1) % 256;
            n_samp++;
        end
        e = '{m_sample, m_gain, m_locked, m_amp};
        sb_q.push_back(e);
        @(posedge i_clock);
        #2;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1);
        total++;
        if (o_gain !== 16'd256) begin
            bad++; $display("FAIL reset_gain got=%0d want=256", o_gain);
        end
        total++;
        if (o_sample !== 16'sd0) begin
            bad++; $display("FAIL reset_sample got=%0d want=0", o_sample);
        end
        total++;
        if (o_locked !== 1'b0) begin
            bad++; $display("FAIL reset_locked got=%0b want=0", o_locked);
        end
        total++;
        if (o_amp_idx !== 2'd0) begin
            bad++; $display("FAIL reset_amp got=%0d want=0", o_amp_idx);
        end
    endtask

    task automatic test_first_samples();
        drive_cycle(1'b0);
        total++;
        if (o_sample !== -16'sd2048) begin
            bad++; $display("FAIL first_sample got=%0d want=-2048", o_sample);
        end
        drive_cycle(1'b0);
        total++;
        if (o_sample !== -16'sd2016) begin
            bad++; $display("FAIL second_sample got=%0d want=-2016", o_sample);
        end
    endtask

    task automatic test_first_block_end();
        while (n_samp < BLK) drive_cycle(1'b0);
        total++;
        if (o_gain !== 16'd273 || o_locked !== 1'b0) begin
            bad++; $display("FAIL block1_gain got gain=%0d locked=%0b want gain=273 locked=0", o_gain, o_locked);
        end
        drive_cycle(1'b0);
        total++;
        if (o_sample !== -16'sd2184) begin
            bad++; $display("FAIL sample257 got=%0d want=-2184", o_sample);
        end
    endtask

    task automatic test_run_segments();
        int   g_seg1 = 0;
        logic seen_lock = 1'b0;
        logic seen_hi   = 1'b0;
        logic seen_lo   = 1'b0;
        while (n_samp < 64 * BLK + 8) begin
            drive_cycle(1'b0);
            if (o_locked === 1'b1) seen_lock = 1'b1;
            if (o_amp_idx === 2'd2 && o_sample === 16'sd32767)  seen_hi = 1'b1;
            if (o_amp_idx === 2'd2 && o_sample === -16'sd32768) seen_lo = 1'b1;
            if (n_samp == 16 * BLK) begin
                g_seg1 = int'(o_gain);
                total++;
                if (o_amp_idx !== 2'd1) begin
                    bad++; $display("FAIL amp_step got=%0d want=1", o_amp_idx);
                end
            end
            if (n_samp == 17 * BLK) begin
                total++;
                if (!(int'(o_gain) < g_seg1) || o_locked !== 1'b0) begin
                    bad++; $display("FAIL overshoot_dec got gain=%0d locked=%0b want gain<%0d locked=0",
                                    o_gain, o_locked, g_seg1);
                end
            end
            if (n_samp == 64 * BLK - 1) begin
                total++;
                if (o_amp_idx !== 2'd3) begin
                    bad++; $display("FAIL amp_last got=%0d want=3", o_amp_idx);
                end
            end
            if (n_samp == 64 * BLK) begin
                total++;
                if (o_amp_idx !== 2'd0) begin
                    bad++; $display("FAIL amp_wrap got=%0d want=0", o_amp_idx);
                end
            end
        end
        total++;
        if (seen_lock !== 1'b1) begin
            bad++; $display("FAIL lock_seen got=%0b want=1", seen_lock);
        end
        total++;
        if (seen_hi !== 1'b1 || seen_lo !== 1'b1) begin
            bad++; $display("FAIL saturation got hi=%0b lo=%0b want hi=1 lo=1", seen_hi, seen_lo);
        end
    endtask

    task automatic test_mid_reset();
        drive_cycle(1'b1);
        while (n_samp < 5 * BLK + 100) drive_cycle(1'b0);
        drive_cycle(1'b1);
        total++;
        if (o_sample !== 16'sd0 || o_gain !== 16'd256 || o_locked !== 1'b0 || o_amp_idx !== 2'd0) begin
            bad++; $display("FAIL mid_reset got sample=%0d gain=%0d locked=%0b amp=%0d want 0/256/0/0",
                            o_sample, o_gain, o_locked, o_amp_idx);
        end
        drive_cycle(1'b0);
        total++;
        if (o_sample !== -16'sd2048) begin
            bad++; $display("FAIL phase_restart got=%0d want=-2048", o_sample);
        end
    endtask

    initial begin
        test_reset();
        test_first_samples();
        test_first_block_end();
        test_run_segments();
        test_mid_reset();
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL sb_drain got=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_agc_top
`default_nettype wire
